mem_wb_pipe_reg: RTL and testbench
==================================

// Module: mem_wb_pipe_reg
// PURPOSE
//  Parametrised MEM->WB pipeline register for the CPU datapath. Replaces the fixed 32-bit latch with:
//   - a valid/ready handshake and a 2-entry skid buffer, so upstream ready is registered;
//   - flush, and a write-back data select (load data vs ALU result);
//   - r0 write suppression.
//  Sits between the data-memory stage and the register-file write port.
// PARAMETERS
//  DATA_W  32  width of ALU result, memory read data and write-back data
//  REG_AW  5   register index width (2**REG_AW architectural registers)
// PORTS
//  clk            in   1       clock; all state updates on rising edge
//  rst            in   1       synchronous, active-low reset
//  flush          in   1       discard all buffered entries (pipeline redirect)
//  in_valid       in   1       upstream entry valid
//  in_ready       out  1       register can accept; registered output
//  in_wb_en       in   1       entry writes the register file
//  in_mem_r_en    in   1       entry is a load; select memory data
//  in_alu_result  in   DATA_W  ALU result / memory address
//  in_mem_rdata   in   DATA_W  data read from memory
//  in_dest        in   REG_AW  destination register index
//  out_valid      out  1       head entry valid
//  out_ready      in   1       write-back stage accepts head entry
//  out_wb_en      out  1       in_wb_en & out_valid & (dest != 0)
//  out_wb_data    out  DATA_W  mem_r_en ? mem_rdata : alu_result of head entry
//  out_dest       out  REG_AW  head destination
//  out_mem_r_en   out  1       head entry is a load (hazard unit)
// BEHAVIOUR
//  - Fire events: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
//  - State: EMPTY (no entry), ONE (main slot valid), FULL (main + skid valid).
//    - EMPTY: in_fire -> ONE; main <= input.
//    - ONE:
//      - in_fire & out_fire -> ONE; main <= input.
//      - in_fire & !out_fire -> FULL; skid <= input.
//      - !in_fire & out_fire -> EMPTY.
//    - FULL (in_ready=0):
//      - out_fire -> ONE; main <= skid.
//      - else hold.
//  - in_ready is registered: next-state != FULL. It never depends combinationally on out_ready.
//  - Latency: 1 cycle from in_fire to out_valid. Throughput: 1 entry/cycle sustained.
//  - Ordering: strictly FIFO; the skid entry never overtakes the main entry.
//  - out_* payload comes from the main slot. Payload may be X-free stale data when out_valid=0;
//    out_wb_en is always 0 when out_valid=0.
//  - dest==0: the entry still flows, but out_wb_en=0 (r0 hard-wired).
//  - out_wb_data mux is combinational from stored fields. Both DATA_W values are stored unmodified;
//    there is no sign/zero extension here.
//  - flush=1 (rst high):
//    - next state EMPTY; in_fire is ignored that cycle; in_ready=1 next cycle.
//    - out_fire in the same cycle still counts for the consumer (entry is consumed, not replayed).
//  - Reset (rst=0 at edge), highest priority over flush and fires:
//    - state EMPTY, out_valid=0, in_ready=1;
//    - main/skid payload cleared to 0, so out_wb_data=0, out_dest=0, out_mem_r_en=0, out_wb_en=0.
//    - Reset mid-transfer drops all entries, including a FULL skid.
// CONFIGURATION
//  MEM_WB_PERF_EN defined:
//    - adds ports stall_cnt (out, 32) and flush_cnt (out, 32).
//    - stall_cnt +1 each cycle with out_valid & !out_ready.
//    - flush_cnt +1 each cycle flush=1 while state != EMPTY.
//    - Both counters saturate at 2**32-1 and clear on reset.
//  MEM_WB_PERF_EN undefined: ports and counters absent; no other behavioural difference.
// STRUCTURE
//  - Package mem_wb_pkg:
//    - typedef mem_wb_payload_t {wb_en, mem_r_en, alu_result, mem_rdata, dest}, sized from
//      DATA_W/REG_AW constants;
//    - enum mem_wb_state_e {EMPTY, ONE, FULL}.
//  - Sub-module pipe_skid_buf (param PAYLOAD_W): generic 2-entry skid buffer with handshake and
//    flush. The top packs and unpacks the payload and adds the wb_data mux, r0 gating and
//    optional counters.
// TESTING
//  1. Reset: hold rst=0 3 cycles with in_valid=1 -> out_valid=0, out_wb_en=0, in_ready=1
//     the cycle after release.
//  2. Stream: 4 entries back-to-back, out_ready=1; ALU 0x10,0x20,load 0xDEAD,0x40; dest 1..4
//     -> same order, 1 cycle later, wb_data 0x10,0x20,0xDEAD,0x40.
//  3. Backpressure: out_ready=0 after entry A, send B, C
//     -> B captured in skid, in_ready=0 next cycle, C held upstream;
//     release -> A, B, C delivered in order, no loss or duplication.
//  4. Flush in FULL: flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1;
//     the new entry is not delivered.
//  5. r0: entry wb_en=1, dest=0, alu=0x55 -> out_valid=1, out_wb_en=0, out_wb_data=0x55.
//  6. MEM_WB_PERF_EN: 5 stalled cycles, then flush in ONE -> stall_cnt=5, flush_cnt=1;
//     reset -> both 0.

Source files
------------

// File: rtl/mem_wb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_wb_pkg
//  Description : Shared types and constants for the MEM->WB pipeline register.
//                Provides the default payload layout, the skid-buffer state
//                encoding and a helper that sizes the packed payload vector.
//  Revision    : 1.0  initial release
// ============================================================================
package mem_wb_pkg;

    localparam int unsigned c_data_w = 32;
    localparam int unsigned c_reg_aw = 5;

    // Field order here is the same MSB-to-LSB order the top uses when it
    // packs the payload into a flat vector for the skid buffer.
    typedef struct packed {
        logic                wb_en;
        logic                mem_r_en;
        logic [c_data_w-1:0] alu_result;
        logic [c_data_w-1:0] mem_rdata;
        logic [c_reg_aw-1:0] dest;
    } mem_wb_payload_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } mem_wb_state_e;

    function automatic int unsigned payload_width(input int unsigned data_w,
                                                  input int unsigned reg_aw);
        return 2 + 2 * data_w + reg_aw;
    endfunction

endpackage : mem_wb_pkg
`default_nettype wire

// File: rtl/pipe_skid_buf.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_skid_buf
//  Description : Generic 2-entry skid buffer with valid/ready handshake and
//                flush. in_ready is a registered output, so it never depends
//                combinationally on out_ready. Strict FIFO ordering.
//  Ports       : clk, rst (sync, active-low), flush,
//                in_valid / in_ready / in_data   - upstream side
//                out_valid / out_ready / out_data - downstream side (main slot)
//  Revision    : 1.0  initial release
// ============================================================================
module pipe_skid_buf
    import mem_wb_pkg::*;
#(
    parameter int unsigned PAYLOAD_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PAYLOAD_W-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PAYLOAD_W-1:0] out_data
);

    mem_wb_state_e          state_q, state_d;
    logic [PAYLOAD_W-1:0]   main_q,  main_d;
    logic [PAYLOAD_W-1:0]   skid_q,  skid_d;
    logic                   in_ready_q;

    logic                   w_in_fire;
    logic                   w_out_fire;

    assign w_in_fire  = in_valid  & in_ready_q;
    assign w_out_fire = out_valid & out_ready;

    assign in_ready  = in_ready_q;
    assign out_valid = (state_q != EMPTY);
    assign out_data  = main_q;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            // Everything buffered is dropped and any input this cycle is
            // ignored; a same-cycle out_fire simply counts as consumed.
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (w_in_fire) begin
                        state_d = ONE;
                        main_d  = in_data;
                    end
                end
                ONE: begin
                    if (w_in_fire && w_out_fire) begin
                        main_d  = in_data;
                    end else if (w_in_fire) begin
                        state_d = FULL;
                        skid_d  = in_data;
                    end else if (w_out_fire) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    // in_ready_q is low here, so no input can arrive.
                    if (w_out_fire) begin
                        state_d = ONE;
                        main_d  = skid_q;
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= EMPTY;
            main_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            in_ready_q <= (state_d != FULL);
        end
    end

endmodule : pipe_skid_buf
`default_nettype wire

// File: rtl/mem_wb_pipe_reg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_wb_pipe_reg
//  Description : MEM->WB pipeline register built on a 2-entry skid buffer.
//                Packs the stage payload, selects write-back data (load data
//                vs ALU result) and suppresses writes to r0.
//  Ports       : clk, rst (sync, active-low), flush
//                in_valid/in_ready, in_wb_en, in_mem_r_en, in_alu_result,
//                in_mem_rdata, in_dest                      - MEM side
//                out_valid/out_ready, out_wb_en, out_wb_data,
//                out_dest, out_mem_r_en                     - WB side
//                stall_cnt, flush_cnt                       - perf (optional)
//  Options     : MEM_WB_PERF_EN - adds saturating stall/flush counters.
//  Revision    : 1.0  initial release
// ============================================================================
module mem_wb_pipe_reg
    import mem_wb_pkg::*;
#(
    parameter int unsigned DATA_W = c_data_w,
    parameter int unsigned REG_AW = c_reg_aw
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_wb_en,
    input  logic              in_mem_r_en,
    input  logic [DATA_W-1:0] in_alu_result,
    input  logic [DATA_W-1:0] in_mem_rdata,
    input  logic [REG_AW-1:0] in_dest,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_wb_en,
    output logic [DATA_W-1:0] out_wb_data,
    output logic [REG_AW-1:0] out_dest,
    output logic              out_mem_r_en
`ifdef MEM_WB_PERF_EN
    ,
    output logic [31:0]       stall_cnt,
    output logic [31:0]       flush_cnt
`endif
);

    localparam int unsigned c_payload_w = payload_width(DATA_W, REG_AW);

    logic [c_payload_w-1:0] w_in_payload;
    logic [c_payload_w-1:0] w_out_payload;

    logic                   w_head_wb_en;
    logic                   w_head_mem_r_en;
    logic [DATA_W-1:0]      w_head_alu;
    logic [DATA_W-1:0]      w_head_rdata;
    logic [REG_AW-1:0]      w_head_dest;

    assign w_in_payload = {in_wb_en, in_mem_r_en, in_alu_result, in_mem_rdata, in_dest};

    pipe_skid_buf #(
        .PAYLOAD_W (c_payload_w)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (w_in_payload),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (w_out_payload)
    );

    assign {w_head_wb_en, w_head_mem_r_en, w_head_alu, w_head_rdata, w_head_dest} = w_out_payload;

    // r0 is hard-wired: the entry still flows but never writes.
    assign out_wb_en    = w_head_wb_en & out_valid & (w_head_dest != '0);
    assign out_wb_data  = w_head_mem_r_en ? w_head_rdata : w_head_alu;
    assign out_dest     = w_head_dest;
    assign out_mem_r_en = w_head_mem_r_en;

`ifdef MEM_WB_PERF_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] flush_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (out_valid && !out_ready && (stall_cnt_q != 32'hFFFF_FFFF)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            // out_valid is high exactly when the buffer is not EMPTY.
            if (flush && out_valid && (flush_cnt_q != 32'hFFFF_FFFF)) begin
                flush_cnt_q <= flush_cnt_q + 32'd1;
            end
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    // Performance counters not built.
`endif

endmodule : mem_wb_pipe_reg
`default_nettype wire

// File: tb/tb_mem_wb_pipe_reg.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_wb_pipe_reg
//  Description : Directed self-checking bench for mem_wb_pipe_reg.
//                Inputs change 1 time unit after the rising edge; outputs are
//                sampled at that same point, well away from the next edge.
//                Build with MEM_WB_PERF_EN to include the counter checks.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mem_wb_pipe_reg;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic        in_wb_en;
    logic        in_mem_r_en;
    logic [31:0] in_alu_result;
    logic [31:0] in_mem_rdata;
    logic [4:0]  in_dest;
    logic        out_valid;
    logic        out_ready;
    logic        out_wb_en;
    logic [31:0] out_wb_data;
    logic [4:0]  out_dest;
    logic        out_mem_r_en;
`ifdef MEM_WB_PERF_EN
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_wb_pipe_reg dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_wb_en      (in_wb_en),
        .in_mem_r_en   (in_mem_r_en),
        .in_alu_result (in_alu_result),
        .in_mem_rdata  (in_mem_rdata),
        .in_dest       (in_dest),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_wb_en     (out_wb_en),
        .out_wb_data   (out_wb_data),
        .out_dest      (out_dest),
        .out_mem_r_en  (out_mem_r_en)
`ifdef MEM_WB_PERF_EN
        ,
        .stall_cnt     (stall_cnt),
        .flush_cnt     (flush_cnt)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic wb, input logic ld,
                         input logic [31:0] alu, input logic [31:0] rd,
                         input logic [4:0] dst);
        in_valid      = v;
        in_wb_en      = wb;
        in_mem_r_en   = ld;
        in_alu_result = alu;
        in_mem_rdata  = rd;
        in_dest       = dst;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Checks the head entry: valid, write enable, data, destination.
    task automatic chk_head(input string tag, input logic v, input logic wb,
                            input logic [31:0] data, input logic [4:0] dst);
        chk({tag, ".valid"}, {31'd0, out_valid}, {31'd0, v});
        chk({tag, ".wb_en"}, {31'd0, out_wb_en}, {31'd0, wb});
        chk({tag, ".data"},  out_wb_data, data);
        chk({tag, ".dest"},  {27'd0, out_dest}, {27'd0, dst});
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---------------- 1. reset with in_valid high ----------------
        rst = 1'b0; flush = 1'b0; out_ready = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 32'h99, 32'h0, 5'd7);
        tick(); tick(); tick();
        chk("rst.out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst.out_wb_en", {31'd0, out_wb_en}, 32'd0);
        chk("rst.in_ready",  {31'd0, in_ready},  32'd1);
        chk("rst.wb_data",   out_wb_data,        32'd0);
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        tick();
        chk("rel.out_valid", {31'd0, out_valid}, 32'd0);
        chk("rel.in_ready",  {31'd0, in_ready},  32'd1);

        // ---------------- 2. back-to-back stream ----------------
        out_ready = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 32'h10, 32'hBAD0, 5'd1);
        tick();
        chk_head("s1", 1'b1, 1'b1, 32'h10, 5'd1);
        drive(1'b1, 1'b1, 1'b0, 32'h20, 32'hBAD1, 5'd2);
        tick();
        chk_head("s2", 1'b1, 1'b1, 32'h20, 5'd2);
        chk("s2.in_ready", {31'd0, in_ready}, 32'd1);
        drive(1'b1, 1'b1, 1'b1, 32'h30, 32'hDEAD, 5'd3);
        tick();
        chk_head("s3", 1'b1, 1'b1, 32'hDEAD, 5'd3);
        chk("s3.mem_r_en", {31'd0, out_mem_r_en}, 32'd1);
        drive(1'b1, 1'b1, 1'b0, 32'h40, 32'hBAD3, 5'd4);
        tick();
        chk_head("s4", 1'b1, 1'b1, 32'h40, 5'd4);
        chk("s4.mem_r_en", {31'd0, out_mem_r_en}, 32'd0);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        tick();
        chk("s.drain", {31'd0, out_valid}, 32'd0);

        // ---------------- 3. backpressure into skid ----------------
        out_ready = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 32'hA1, 32'h0, 5'd5);
        tick();
        chk_head("bpA", 1'b1, 1'b1, 32'hA1, 5'd5);
        chk("bpA.in_ready", {31'd0, in_ready}, 32'd1);
        drive(1'b1, 1'b1, 1'b0, 32'hB2, 32'h0, 5'd6);
        tick();
        chk_head("bpB", 1'b1, 1'b1, 32'hA1, 5'd5);
        chk("bpB.in_ready", {31'd0, in_ready}, 32'd0);
        drive(1'b1, 1'b1, 1'b0, 32'hC3, 32'h0, 5'd7);
        tick();
        chk_head("bpC.hold", 1'b1, 1'b1, 32'hA1, 5'd5);
        chk("bpC.in_ready", {31'd0, in_ready}, 32'd0);
        out_ready = 1'b1;
        tick();
        chk_head("bp.rel1", 1'b1, 1'b1, 32'hB2, 5'd6);
        chk("bp.rel1.in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        chk_head("bp.rel2", 1'b1, 1'b1, 32'hC3, 5'd7);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        tick();
        chk("bp.drain", {31'd0, out_valid}, 32'd0);

        // ---------------- 4. flush in FULL and in ONE ----------------
        out_ready = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 32'hD4, 32'h0, 5'd8);
        tick();
        drive(1'b1, 1'b1, 1'b0, 32'hE5, 32'h0, 5'd9);
        tick();
        chk("fl.full.in_ready", {31'd0, in_ready}, 32'd0);
        flush = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 32'hF6, 32'h0, 5'd10);
        tick();
        chk("fl.full.out_valid", {31'd0, out_valid}, 32'd0);
        chk("fl.full.in_ready",  {31'd0, in_ready},  32'd1);
        chk("fl.full.wb_en",     {31'd0, out_wb_en}, 32'd0);
        flush = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        tick();
        chk("fl.full.after", {31'd0, out_valid}, 32'd0);
        drive(1'b1, 1'b1, 1'b0, 32'h61, 32'h0, 5'd11);
        tick();
        chk_head("fl.one.load", 1'b1, 1'b1, 32'h61, 5'd11);
        flush = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 32'h62, 32'h0, 5'd12);
        tick();
        chk("fl.one.out_valid", {31'd0, out_valid}, 32'd0);
        chk("fl.one.in_ready",  {31'd0, in_ready},  32'd1);
        flush = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        tick();
        chk("fl.one.after", {31'd0, out_valid}, 32'd0);

        // ---------------- 5. r0 write suppression ----------------
        drive(1'b1, 1'b1, 1'b0, 32'h55, 32'h0, 5'd0);
        tick();
        chk_head("r0", 1'b1, 1'b0, 32'h55, 5'd0);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        out_ready = 1'b1;
        tick();
        chk("r0.drain", {31'd0, out_valid}, 32'd0);

        // ---------------- reset while FULL ----------------
        out_ready = 1'b0;
        drive(1'b1, 1'b1, 1'b1, 32'h71, 32'h1234, 5'd13);
        tick();
        drive(1'b1, 1'b1, 1'b0, 32'h72, 32'h0, 5'd14);
        tick();
        chk("rf.in_ready", {31'd0, in_ready}, 32'd0);
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        tick();
        chk_head("rf.rst", 1'b0, 1'b0, 32'h0, 5'd0);
        chk("rf.rst.in_ready", {31'd0, in_ready},     32'd1);
        chk("rf.rst.mem_r_en", {31'd0, out_mem_r_en}, 32'd0);
        rst = 1'b1;
        out_ready = 1'b1;
        tick();
        chk("rf.after", {31'd0, out_valid}, 32'd0);

`ifdef MEM_WB_PERF_EN
        // ---------------- 6. performance counters ----------------
        chk("perf.init.stall", stall_cnt, 32'd0);
        chk("perf.init.flush", flush_cnt, 32'd0);
        out_ready = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 32'h81, 32'h0, 5'd15);
        tick();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        for (int i = 0; i < 5; i++) tick();
        chk("perf.stall5", stall_cnt, 32'd5);
        flush = 1'b1;
        out_ready = 1'b1;
        tick();
        flush = 1'b0;
        chk("perf.stall", stall_cnt, 32'd5);
        chk("perf.flush", flush_cnt, 32'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("perf.flush.empty", flush_cnt, 32'd1);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk("perf.rst.stall", stall_cnt, 32'd0);
        chk("perf.rst.flush", flush_cnt, 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_mem_wb_pipe_reg
`default_nettype wire
